// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a single-port, variable-latency data RAM.
// Accepts one access at a time, stalls the pipeline while it is outstanding,
// and returns extended load data together with writeback controls.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  rd_addr_o,
  output logic        wreg_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        dram_req_o,
  output logic        dram_we_o,
  output logic [31:0] dram_addr_o,
  output logic [3:0]  dram_be_o,
  output logic [31:0] dram_wdata_o,
  input  logic        dram_ack_i,
  input  logic [31:0] dram_rdata_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        we;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [4:0]  rd;
  logic        stall_r;
  logic        err_r;
  logic [1:0]  code_r;

  logic        idle_req;
  logic        illegal;
  logic        misal;
  logic        accept;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Request decode: illegal width has priority over misalignment.
  always_comb begin
    idle_req = (state == StIdle) && req_valid_i;
    illegal  = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) ||
               (req_we_i && funct3_i[2]);
    misal    = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
               ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    accept   = idle_req && !illegal && !misal;
  end

  // Byte enables and lane-replicated store data for a newly accepted access.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << addr_i[1:0];
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
    if (!req_we_i) wdata_new = 32'h0;
  end

  // Align the returned word to the addressed lane and extend to 32 bits.
  always_comb begin
    shifted = dram_rdata_i >> {off, 3'b000};
    unique case (f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Accept stalls in the same cycle; request faults are reported without a state change.
  always_comb begin
    stall_o    = stall_r | accept;
    err_o      = err_r | (idle_req && (illegal || misal));
    err_code_o = 2'b00;
    if (err_r)                   err_code_o = code_r;
    else if (idle_req && illegal) err_code_o = 2'b10;
    else if (idle_req && misal)   err_code_o = 2'b01;
  end

  // Access FSM with registered RAM interface and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= 8'h0;
      we           <= 1'b0;
      f3           <= 3'b000;
      off          <= 2'b00;
      rd           <= 5'h0;
      stall_r      <= 1'b0;
      err_r        <= 1'b0;
      code_r       <= 2'b00;
      done_o       <= 1'b0;
      rdata_o      <= 32'h0;
      rd_addr_o    <= 5'h0;
      wreg_o       <= 1'b0;
      dram_req_o   <= 1'b0;
      dram_we_o    <= 1'b0;
      dram_addr_o  <= 32'h0;
      dram_be_o    <= 4'h0;
      dram_wdata_o <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            state        <= StBusy;
            cnt          <= 8'h0;
            we           <= req_we_i;
            f3           <= funct3_i;
            off          <= addr_i[1:0];
            rd           <= rd_addr_i;
            stall_r      <= 1'b1;
            dram_req_o   <= 1'b1;
            dram_we_o    <= req_we_i;
            dram_addr_o  <= {addr_i[31:2], 2'b00};
            dram_be_o    <= be_new;
            dram_wdata_o <= wdata_new;
          end
        end
        StBusy: begin
          if (dram_ack_i || (cnt == CntMax)) begin
            state        <= StDone;
            stall_r      <= 1'b0;
            dram_req_o   <= 1'b0;
            dram_we_o    <= 1'b0;
            dram_addr_o  <= 32'h0;
            dram_be_o    <= 4'h0;
            dram_wdata_o <= 32'h0;
            if (dram_ack_i) begin
              done_o    <= 1'b1;
              rd_addr_o <= rd;
              rdata_o   <= we ? 32'h0 : load_val;
              wreg_o    <= !we && (rd != 5'h0);
            end else begin
              err_r  <= 1'b1;
              code_r <= 2'b11;
            end
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: begin
          // Completion lasts one cycle; req_valid_i is not looked at here.
          state     <= StIdle;
          done_o    <= 1'b0;
          err_r     <= 1'b0;
          code_r    <= 2'b00;
          rdata_o   <= 32'h0;
          rd_addr_o <= 5'h0;
          wreg_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized accesses checked
// against a behavioural model of widths, lanes, extension and timeouts.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic [4:0]  rd_addr_o;
  logic        wreg_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        dram_req_o;
  logic        dram_we_o;
  logic [31:0] dram_addr_o;
  logic [3:0]  dram_be_o;
  logic [31:0] dram_wdata_o;
  logic        dram_ack_i;
  logic [31:0] dram_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rd_addr_i    (rd_addr_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .rd_addr_o    (rd_addr_o),
    .wreg_o       (wreg_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .dram_req_o   (dram_req_o),
    .dram_we_o    (dram_we_o),
    .dram_addr_o  (dram_addr_o),
    .dram_be_o    (dram_be_o),
    .dram_wdata_o (dram_wdata_o),
    .dram_ack_i   (dram_ack_i),
    .dram_rdata_i (dram_rdata_i)
  );

  // One access end to end. Starts in an IDLE cycle at posedge+1, returns in the
  // IDLE cycle following DONE (so consecutive calls are back-to-back).
  // delay = number of BUSY cycles before the ack cycle; delay >= TO means no ack.
  task automatic do_access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wd, input bit [4:0] rd, input int delay,
                           input bit [31:0] word, input string tag);
    int          w;
    bit          legal, aligned, timed_out;
    bit   [3:0]  e_be;
    bit   [31:0] e_wd, e_rd, mask;
    int          busy;
    bit          fin;
    // Reference model from the instruction's meaning
    w       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal   = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    aligned = (addr % w) == 0;
    e_be    = 4'(((1 << w) - 1) << (addr % 4));
    e_wd    = (w == 1) ? wd[7:0] * 32'h01010101 : (w == 2) ? wd[15:0] * 32'h00010001 : wd;
    mask    = (w == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * w)) - 1;
    e_rd    = (word >> (8 * (addr % 4))) & mask;
    if (!f3[2] && w < 4 && e_rd[8*w-1]) e_rd = e_rd | ~mask;
    if (we) e_rd = 32'h0;
    timed_out = delay >= int'(TO);

    req_valid_i = 1'b1; req_we_i = we; funct3_i = f3; addr_i = addr;
    wdata_i = wd; rd_addr_i = rd;
    #1;
    if (!legal || !aligned) begin
      n_tests++;
      if (err_o !== 1'b1 || err_code_o !== (legal ? 2'b01 : 2'b10) || stall_o !== 1'b0)
        begin n_fail++; $display("FAIL %s reqerr: err=%b code=%b stall=%b, expected err=1 code=%b stall=0",
                                 tag, err_o, err_code_o, stall_o, legal ? 2'b01 : 2'b10); end
      @(posedge clk); #1;
      req_valid_i = 1'b0; #1;
      n_tests++;
      if (dram_req_o !== 1'b0 || err_o !== 1'b0 || stall_o !== 1'b0)
        begin n_fail++; $display("FAIL %s reqerr_after: req=%b err=%b stall=%b, expected all 0",
                                 tag, dram_req_o, err_o, stall_o); end
      return;
    end
    n_tests++;
    if (stall_o !== 1'b1 || err_o !== 1'b0 || dram_req_o !== 1'b0)
      begin n_fail++; $display("FAIL %s accept: stall=%b err=%b req=%b, expected 1 0 0",
                               tag, stall_o, err_o, dram_req_o); end

    busy = 0; fin = 0;
    while (!fin) begin
      @(posedge clk); #1;
      n_tests++;
      if (dram_req_o !== 1'b1 || stall_o !== 1'b1 || dram_we_o !== we ||
          dram_addr_o !== {addr[31:2], 2'b00} || dram_be_o !== e_be ||
          (we && dram_wdata_o !== e_wd) || done_o !== 1'b0)
        begin n_fail++; $display("FAIL %s busy%0d: req=%b stall=%b we=%b addr=%h be=%b wd=%h, expected 1 1 %b %h %b %h",
                                 tag, busy, dram_req_o, stall_o, dram_we_o, dram_addr_o, dram_be_o,
                                 dram_wdata_o, we, {addr[31:2], 2'b00}, e_be, e_wd); end
      if (busy == delay) begin
        dram_ack_i = 1'b1; dram_rdata_i = word; fin = 1;
      end else begin
        dram_rdata_i = $urandom;
        if (busy == int'(TO) - 1) fin = 1;
      end
      busy++;
    end

    @(posedge clk); #1;
    dram_ack_i = 1'b0; dram_rdata_i = $urandom; #1;
    n_tests++;
    if (timed_out) begin
      if (done_o !== 1'b0 || err_o !== 1'b1 || err_code_o !== 2'b11 || wreg_o !== 1'b0 ||
          stall_o !== 1'b0 || dram_req_o !== 1'b0)
        begin n_fail++; $display("FAIL %s timeout: done=%b err=%b code=%b wreg=%b stall=%b req=%b, expected 0 1 11 0 0 0",
                                 tag, done_o, err_o, err_code_o, wreg_o, stall_o, dram_req_o); end
    end else begin
      if (done_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== e_rd || rd_addr_o !== rd ||
          wreg_o !== (!we && rd != 0) || stall_o !== 1'b0 || dram_req_o !== 1'b0)
        begin n_fail++; $display("FAIL %s done: done=%b err=%b rdata=%h rd=%0d wreg=%b stall=%b req=%b, expected 1 0 %h %0d %b 0 0",
                                 tag, done_o, err_o, rdata_o, rd_addr_o, wreg_o, stall_o, dram_req_o,
                                 e_rd, rd, !we && rd != 0); end
    end
    // req_valid_i is still high during DONE; it must not be re-issued.
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || dram_req_o !== 1'b0 || stall_o !== 1'b0)
      begin n_fail++; $display("FAIL %s after: done=%b err=%b req=%b stall=%b, expected all 0",
                               tag, done_o, err_o, dram_req_o, stall_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    wdata_i = 32'h0; rd_addr_i = 5'h0; dram_ack_i = 1'b0; dram_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({stall_o, done_o, rdata_o, rd_addr_o, wreg_o, err_o, err_code_o, dram_req_o,
         dram_we_o, dram_addr_o, dram_be_o, dram_wdata_o} !== '0)
      begin n_fail++; $display("FAIL reset: outputs not all zero (stall=%b req=%b done=%b err=%b)",
                               stall_o, dram_req_o, done_o, err_o); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 2, 32'hDEADBEEF, "lw");
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 1, 32'h80112233, "lb");
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, 0, 32'h80112233, "lbu");
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 5'd0, 0, 32'h9ABC1234, "lh_rd0");
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 1, 32'h9ABC1234, "lhu");
  endtask

  task automatic test_stores();
    do_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd4, 0, 32'h0, "sh");
    do_access(1'b1, 3'b000, 32'h301, 32'h123456A5, 5'd4, 1, 32'h0, "sb");
    do_access(1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 5'd4, 2, 32'h0, "sw");
  endtask

  task automatic test_errors();
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 5'd1, 0, 32'h0, "lw_misal");
    do_access(1'b1, 3'b100, 32'h100, 32'h0, 5'd1, 0, 32'h0, "sw_f3_100");
    do_access(1'b0, 3'b011, 32'h103, 32'h0, 5'd1, 0, 32'h0, "f3_011_prio");
    do_access(1'b0, 3'b101, 32'h101, 32'h0, 5'd1, 0, 32'h0, "lhu_misal");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 5'd2, 10, 32'h0, "timeout");
    do_access(1'b0, 3'b010, 32'h400, 32'h0, 5'd2, int'(TO) - 1, 32'h55AA55AA, "ack_at_limit");
  endtask

  task automatic test_reset_busy();
    req_valid_i = 1'b1; req_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h500; rd_addr_i = 5'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_tests++;
    if (dram_req_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0)
      begin n_fail++; $display("FAIL reset_busy: req=%b stall=%b done=%b err=%b, expected all 0",
                               dram_req_o, stall_o, done_o, err_o); end
    do_access(1'b0, 3'b010, 32'h504, 32'h0, 5'd6, 1, 32'h01020304, "lw_after_rst");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 3'b010, 32'h600, 32'h11112222, 5'd1, 0, 32'h0, "b2b_a");
    do_access(1'b0, 3'b010, 32'h600, 32'h0, 5'd1, 0, 32'h11112222, "b2b_b");
  endtask

  task automatic test_random();
    bit [2:0] f3s [7];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    for (int i = 0; i < 60; i++) begin
      bit        we;
      bit [2:0]  f3;
      bit [31:0] a;
      int        d;
      we = 1'($urandom_range(0, 1));
      f3 = f3s[$urandom_range(0, 6)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom_range(0, 5);
      do_access(we, f3, a, $urandom, 5'($urandom), d, $urandom, "rand");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
